// File: rtl/flash_page_reader_if.sv
// SPI mode-0 bus between the page reader (master) and a serial flash.
// Signal names match the flash pins.
interface flash_page_reader_if;
  logic flashClk;
  logic flashMosi;
  logic flashCs;
  logic flashMiso;

  modport master (
    output flashClk,
    output flashMosi,
    output flashCs,
    input  flashMiso
  );

  modport slave (
    input  flashClk,
    input  flashMosi,
    input  flashCs,
    output flashMiso
  );
endinterface

// File: rtl/flash_page_reader.sv
// Reads one flash page over SPI into a shadow buffer, then swaps it
// into the display buffer; buttons step the page address up or down.
module flash_page_reader #(
  parameter int          PAGE_BYTES      = 32,
  parameter int          CLK_DIV         = 1,
  parameter bit          FAST_READ       = 1'b0,
  parameter logic [23:0] START_ADDR      = 24'h000000,
  parameter int          DEBOUNCE_CYCLES = 270000,
  localparam int         AW = $clog2(PAGE_BYTES)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_next,
  input  logic                btn_prev,
  flash_page_reader_if.master spi,
  input  logic [AW-1:0]       charAddress,
  output logic [7:0]          charOutput,
  output logic [23:0]         pageAddr,
  output logic                busy,
  output logic                pageValid
);

  localparam int HDR = 32 + (FAST_READ ? 8 : 0);
  localparam int NR  = HDR + 8 * PAGE_BYTES;
  localparam int CW  = $clog2(NR + 1);
  localparam int DW  = $clog2(2 * CLK_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [7:0] CMD_B = FAST_READ ? 8'h0B : 8'h03;
  localparam logic [23:0] STEP = 24'(PAGE_BYTES);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, READ, SWAP, GAP
  } st_t;

  st_t              st_q;
  logic             cs_q, sck_q, sel_q;
  logic             pend_q, busy_q, pv_q;
  logic [31:0]      tx_q;
  logic [6:0]       rx_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    dcnt_q;
  logic [23:0]      tgt_q, cur_q, page_q;
  logic [7:0]       out_q;
  logic [7:0]       mem_q [2][PAGE_BYTES];

  logic [1:0]       s1_q, s2_q, lvl_q, fire_q;
  logic [DBW-1:0]   db_q [2];
  logic             ev_n, ev_p;
  logic             tick, wr_en;
  logic [CW-1:0]    doff;
  logic [AW-1:0]    widx;

  // index 0 = next, 1 = prev; buttons idle high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      lvl_q  <= 2'b11;
      fire_q <= 2'b00;
      db_q[0] <= '0;
      db_q[1] <= '0;
    end else begin
      s1_q   <= {btn_prev, btn_next};
      s2_q   <= s1_q;
      fire_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == lvl_q[i]) begin
          db_q[i] <= '0;
        end else if (db_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]   <= '0;
          lvl_q[i]  <= s2_q[i];
          fire_q[i] <= lvl_q[i];
        end else begin
          db_q[i] <= db_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev_n = fire_q[0] & ~fire_q[1];
  assign ev_p = fire_q[1] & ~fire_q[0];

  assign tick  = (dcnt_q == DW'(CLK_DIV - 1));
  assign doff  = cnt_q - CW'(HDR);
  assign widx  = AW'(doff >> 3);
  assign wr_en = (st_q == READ) && tick && !sck_q
              && (&cnt_q[2:0]);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[!sel_q][widx] <= {rx_q, spi.flashMiso};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= IDLE;
      cs_q   <= 1'b1;
      sck_q  <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      dcnt_q <= '0;
      sel_q  <= 1'b0;
      pend_q <= 1'b1;
      tgt_q  <= START_ADDR;
      cur_q  <= START_ADDR;
      page_q <= START_ADDR;
      busy_q <= 1'b0;
      pv_q   <= 1'b0;
      out_q  <= 8'h00;
    end else begin
      out_q <= pv_q ? mem_q[sel_q][charAddress] : 8'h00;
      unique case (st_q)
        IDLE: begin
          if (pend_q) begin
            st_q   <= CMD;
            cs_q   <= 1'b0;
            busy_q <= 1'b1;
            pend_q <= 1'b0;
            cur_q  <= tgt_q;
            tx_q   <= {CMD_B, tgt_q};
            cnt_q  <= '0;
            dcnt_q <= '0;
          end
        end
        CMD, ADDR, DUMMY, READ: begin
          if (!tick) begin
            dcnt_q <= dcnt_q + 1'b1;
          end else begin
            dcnt_q <= '0;
            sck_q  <= ~sck_q;
            if (!sck_q) begin
              cnt_q <= cnt_q + 1'b1;
              rx_q  <= {rx_q[5:0], spi.flashMiso};
            end else begin
              tx_q <= tx_q << 1;
              unique case (1'b1)
                cnt_q == CW'(8):  st_q <= ADDR;
                cnt_q == CW'(32): st_q <= FAST_READ ? DUMMY : READ;
                FAST_READ && cnt_q == CW'(40): st_q <= READ;
                cnt_q == CW'(NR): begin
                  st_q <= SWAP;
                  cs_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        SWAP: begin
          sel_q  <= ~sel_q;
          pv_q   <= 1'b1;
          page_q <= cur_q;
          dcnt_q <= '0;
          st_q   <= GAP;
        end
        GAP: begin
          if (dcnt_q == DW'(2 * CLK_DIV - 1)) begin
            dcnt_q <= '0;
            busy_q <= 1'b0;
            st_q   <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
      // a newer event replaces any request not yet started
      if (ev_n || ev_p) begin
        pend_q <= 1'b1;
        tgt_q  <= ev_n ? cur_q + STEP : cur_q - STEP;
      end
    end
  end

  assign spi.flashClk  = sck_q;
  assign spi.flashCs   = cs_q;
  assign spi.flashMosi = tx_q[31];
  assign charOutput    = out_q;
  assign pageAddr      = page_q;
  assign busy          = busy_q;
  assign pageValid     = pv_q;

endmodule

// File: tb/tb_flash_page_reader.sv
// Directed bench for flash_page_reader: two instances (normal and fast
// read) against behavioural SPI flash models with scoreboard queues.
module tb_flash_page_reader;
  typedef struct {
    logic [7:0]  c;
    logic [23:0] a;
    int          r;
  } txn_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic bn = 1'b1;
  logic bp = 1'b1;
  logic [4:0] ca0 = '0;
  logic [4:0] ca1 = '0;
  logic [7:0] co0, co1;
  logic [23:0] pa0, pa1;
  logic bz0, bz1, pv0, pv1;
  int n_vec = 0;
  int n_err = 0;
  txn_t tq0[$];
  txn_t tq1[$];
  logic [23:0] exp_a[$];
  logic [7:0] exp_d[$];

  always #5 clk = ~clk;

  flash_page_reader_if bus0 ();
  flash_page_reader_if bus1 ();

  flash_page_reader #(
    .PAGE_BYTES(32), .CLK_DIV(1), .FAST_READ(1'b0),
    .START_ADDR(24'h000000), .DEBOUNCE_CYCLES(16)
  ) dut0 (
    .clk(clk), .resetn(resetn),
    .btn_next(bn), .btn_prev(bp),
    .spi(bus0), .charAddress(ca0), .charOutput(co0),
    .pageAddr(pa0), .busy(bz0), .pageValid(pv0)
  );

  flash_page_reader #(
    .PAGE_BYTES(32), .CLK_DIV(2), .FAST_READ(1'b1),
    .START_ADDR(24'h000000), .DEBOUNCE_CYCLES(16)
  ) dut1 (
    .clk(clk), .resetn(resetn),
    .btn_next(1'b1), .btn_prev(1'b1),
    .spi(bus1), .charAddress(ca1), .charOutput(co1),
    .pageAddr(pa1), .busy(bz1), .pageValid(pv1)
  );

  function automatic logic [7:0] fb(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  function automatic logic dbit(input logic [23:0] a, input int d);
    logic [7:0] b;
    if (d >= 256) return 1'b0;
    b = fb(a + 24'(d / 8));
    return b[7 - (d % 8)];
  endfunction

  int r0 = 0;
  logic [7:0] c0;
  logic [23:0] a0;
  always @(posedge bus0.flashClk) if (bus0.flashCs === 1'b0) begin
    if (r0 < 8) c0 = {c0[6:0], bus0.flashMosi};
    else if (r0 < 32) a0 = {a0[22:0], bus0.flashMosi};
    r0++;
  end
  always @(negedge bus0.flashClk)
    if (bus0.flashCs === 1'b0 && r0 >= 32) bus0.flashMiso = dbit(a0, r0 - 32);
  always @(negedge bus0.flashCs) r0 = 0;
  always @(posedge bus0.flashCs) if (r0 > 0) tq0.push_back('{c0, a0, r0});

  int r1 = 0;
  logic [7:0] c1;
  logic [23:0] a1;
  time t1a, t1b;
  always @(posedge bus1.flashClk) if (bus1.flashCs === 1'b0) begin
    if (r1 == 0) t1a = $time;
    if (r1 == 1) t1b = $time;
    if (r1 < 8) c1 = {c1[6:0], bus1.flashMosi};
    else if (r1 < 32) a1 = {a1[22:0], bus1.flashMosi};
    r1++;
  end
  always @(negedge bus1.flashClk)
    if (bus1.flashCs === 1'b0 && r1 >= 40) bus1.flashMiso = dbit(a1, r1 - 40);
  always @(negedge bus1.flashCs) r1 = 0;
  always @(posedge bus1.flashCs) if (r1 > 0) tq1.push_back('{c1, a1, r1});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_txn(input int w, output txn_t t);
    int k = 0;
    int sz;
    sz = (w == 0) ? tq0.size() : tq1.size();
    while (sz == 0 && k < 4000) begin
      @(negedge clk);
      k++;
      sz = (w == 0) ? tq0.size() : tq1.size();
    end
    chk("txn_seen", (sz > 0) ? 32'd1 : 32'd0, 32'd1);
    t = '{8'h00, 24'h0, 0};
    if (sz > 0) t = (w == 0) ? tq0.pop_front() : tq1.pop_front();
  endtask

  task automatic wait_idle(input int w);
    int k = 0;
    while (((w == 0) ? bz0 : bz1) !== 1'b0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("idle", (w == 0) ? bz0 : bz1, 1'b0);
  endtask

  task automatic rd(input int w, input logic [4:0] a, input logic [7:0] e);
    exp_d.push_back(e);
    if (w == 0) ca0 = a;
    else ca1 = a;
    @(negedge clk);
    if (w == 0) chk("rd0", co0, exp_d.pop_front());
    else chk("rd1", co1, exp_d.pop_front());
  endtask

  task automatic press(input logic n, input logic p, input int lo);
    bn = ~n;
    bp = ~p;
    repeat (lo) @(negedge clk);
    bn = 1'b1;
    bp = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  initial begin
    txn_t t;
    int k, ns;
    logic [7:0] ov, nv;

    repeat (3) @(negedge clk);
    chk("rst_cs", bus0.flashCs, 1'b1);
    chk("rst_sck", bus0.flashClk, 1'b0);
    chk("rst_mosi", bus0.flashMosi, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    chk("rst_pv", pv0, 1'b0);
    chk("rst_co", co0, 8'h00);
    chk("rst_pa", pa0, 24'h000000);
    chk("rst_cs1", bus1.flashCs, 1'b1);

    exp_a.push_back(24'h000000);
    resetn = 1'b1;
    wait_txn(0, t);
    chk("cmd0", t.c, 8'h03);
    chk("addr0", t.a, exp_a.pop_front());
    chk("rises0", t.r, 288);
    wait_idle(0);
    chk("pv0", pv0, 1'b1);
    chk("pa0", pa0, 24'h000000);
    rd(0, 5'd5, 8'h05);
    rd(0, 5'd31, 8'h1F);
    rd(0, 5'd0, 8'h00);

    wait_txn(1, t);
    chk("cmd1", t.c, 8'h0B);
    chk("addr1", t.a, 24'h000000);
    chk("rises1", t.r, 296);
    chk("period1", 32'((t1b - t1a) / 10), 32'd4);
    wait_idle(1);
    chk("pv1", pv1, 1'b1);
    rd(1, 5'd5, 8'h05);
    rd(1, 5'd20, 8'h14);

    exp_a.push_back(24'hFFFFE0);
    press(1'b0, 1'b1, 24);
    wait_txn(0, t);
    chk("prev_addr", t.a, exp_a.pop_front());
    chk("prev_rises", t.r, 288);
    wait_idle(0);
    chk("prev_pa", pa0, 24'hFFFFE0);
    rd(0, 5'd3, 8'hE3);

    exp_a.push_back(24'h000000);
    press(1'b1, 1'b0, 24);
    wait_txn(0, t);
    chk("wrap_addr", t.a, exp_a.pop_front());
    wait_idle(0);
    chk("wrap_pa", pa0, 24'h000000);
    rd(0, 5'd7, 8'h07);

    exp_a.push_back(24'h000020);
    press(1'b1, 1'b0, 24);
    chk("busy_mid", bz0, 1'b1);
    exp_a.push_back(24'h000040);
    press(1'b1, 1'b0, 24);
    press(1'b1, 1'b0, 24);
    chk("pa_hold", pa0, 24'h000000);
    k = 0;
    ns = 0;
    while (ns < 6 && k < 1500) begin
      ca0 = 5'(k);
      @(negedge clk);
      if (tq0.size() > 0) ns++;
      ov = fb(24'(k % 32));
      nv = fb(24'h000020 + 24'(k % 32));
      chk("sweep", co0, (ns >= 3) ? nv : ov);
      k++;
    end
    wait_txn(0, t);
    chk("p1_addr", t.a, exp_a.pop_front());
    wait_txn(0, t);
    chk("p2_addr", t.a, exp_a.pop_front());
    wait_idle(0);
    chk("p2_pa", pa0, 24'h000040);
    repeat (700) @(negedge clk);
    chk("no_extra", tq0.size(), 0);

    repeat (3) begin
      bn = 1'b0;
      repeat (8) @(negedge clk);
      bn = 1'b1;
      repeat (8) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    chk("bounce_none", tq0.size(), 0);
    chk("bounce_busy", bz0, 1'b0);

    press(1'b1, 1'b1, 24);
    repeat (200) @(negedge clk);
    chk("both_none", tq0.size(), 0);
    chk("both_pa", pa0, 24'h000040);

    exp_a.push_back(24'h000060);
    bn = 1'b0;
    k = 0;
    while (!(bus0.flashCs === 1'b0 && r0 >= 100) && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == 24) bn = 1'b1;
    end
    bn = 1'b1;
    resetn = 1'b0;
    #1;
    chk("ar_cs", bus0.flashCs, 1'b1);
    chk("ar_sck", bus0.flashClk, 1'b0);
    @(negedge clk);
    chk("ar_pv", pv0, 1'b0);
    chk("ar_pa", pa0, 24'h000000);
    chk("ar_busy", bz0, 1'b0);
    chk("ar_co", co0, 8'h00);
    wait_txn(0, t);
    chk("ar_part_addr", t.a, exp_a.pop_front());
    chk("ar_part_rises", t.r, 100);
    tq1.delete();
    repeat (24) @(negedge clk);
    exp_a.push_back(24'h000000);
    resetn = 1'b1;
    wait_txn(0, t);
    chk("fresh_cmd", t.c, 8'h03);
    chk("fresh_addr", t.a, exp_a.pop_front());
    chk("fresh_rises", t.r, 288);
    wait_idle(0);
    chk("fresh_pv", pv0, 1'b1);
    chk("fresh_pa", pa0, 24'h000000);
    rd(0, 5'd9, 8'h09);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
